cpu_state_dumper: RTL and testbench
===================================

Name: cpu_state_dumper

Overview:
- Hardware counterpart of the bench-side register/memory dump. On `start` it reads the register file (x0..x(NUM_REGS-1)), then MEM_WORDS words of data memory.
- It serializes everything as a framed byte stream over a valid/ready byte interface, e.g. into a UART TX.
- It sits beside `cpu`, attached to a spare read port of `rf` and of `dmem`, so state can be inspected on FPGA without a simulator.

Parameters:
- NUM_REGS, 32, registers dumped, starting at x0.
- MEM_WORDS, 16, data-memory words dumped.
- MEM_BASE, 32'h0000_0000, byte address of the first dumped word; word i is at MEM_BASE + 4*i.
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a dump.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse after the checksum byte is transferred.
- rf_addr  out  5  register-file read address.
- rf_data  in  32  register-file read data.
- mem_addr  out  32  data-memory byte address, word aligned.
- mem_data  in  32  data-memory read data.
- tx_data  out  8  output byte.
- tx_valid  out  1  `tx_data` is valid.
- tx_ready  in  1  sink accepts the byte this cycle.

Behaviour:
- Clock/reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, tx_valid=0, tx_data=0, rf_addr=0, mem_addr=MEM_BASE; checksum=0; word index=0.
- Frame format:
  - HDR_BYTE.
  - NUM_REGS words, then MEM_WORDS words, each sent little-endian (bits 7:0 first).
  - One checksum byte = XOR of every payload byte (header excluded).
  - Length = 2 + 4*(NUM_REGS+MEM_WORDS) = 194 bytes at defaults.
- Handshake: a byte transfers on a rising edge where tx_valid && tx_ready. Once raised, tx_valid and tx_data stay stable until transfer. The only exception is reset, which drops tx_valid immediately.
- Read timing: the address is driven in FETCH and the data is captured at the end of LATCH. This tolerates both combinational and one-cycle registered reads.
- The source is the register file while word index < NUM_REGS, otherwise data memory at MEM_BASE + 4*(index-NUM_REGS).
- States:
  - IDLE: busy=0. start=1 -> HDR, clear checksum and index. start while not IDLE is ignored.
  - HDR: tx_valid=1, tx_data=HDR_BYTE. On transfer -> FETCH.
  - FETCH: drive rf_addr/mem_addr for the current index -> LATCH.
  - LATCH: capture the word into the shift register; byte counter=0 -> SEND.
  - SEND: tx_data = low byte of the shift register; XOR it into the checksum on transfer.
    - After the 4th byte: index+1. Go to FETCH if index < NUM_REGS+MEM_WORDS-1, else CSUM.
  - CSUM: tx_data = checksum. On transfer -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in that cycle -> IDLE.
- Latency (tx_ready held 1):
  - start at edge k; header valid in cycle k+1.
  - Each word takes 6 cycles.
  - Checksum valid in cycle k+2+6*(NUM_REGS+MEM_WORDS); done one cycle later. At defaults: header k+1, checksum k+290, done k+291.
- Backpressure: tx_ready=0 stalls in HDR/SEND/CSUM indefinitely. No byte is lost or duplicated.
- Boundary cases:
  - x0 is dumped as read; no special casing.
  - Index and address arithmetic is 32-bit and wraps modulo 2^32; no saturation.
  - start and done are never high in the same cycle. A start arriving in DONE is ignored.
  - Reset mid-frame aborts to IDLE. The partial frame is not completed; the sink detects it via the next HDR_BYTE or a bad checksum.

Decomposition:
- Package `dumper_pkg`:
  - state enum (IDLE, HDR, FETCH, LATCH, SEND, CSUM, DONE);
  - HDR_BYTE default;
  - function frame_len(NUM_REGS, MEM_WORDS).
- One sub-module, `dump_byte_serializer`: loads a 32-bit word, emits 4 bytes LSB-first under valid/ready, reports `last_byte`, and owns the running XOR checksum.
- The top-level FSM handles sequencing and addressing.

Test Plan:
- Registers xi=i, mem[i]=0x1000+i, tx_ready=1, pulse start -> 194 bytes.
  - Byte0 0xA5; bytes1-4 = 00 00 00 00; bytes5-8 = 01 00 00 00.
  - Byte129 = 0x00 and byte130 = 0x10 (mem[0] = 0x00001000).
  - Final byte = XOR of payload; done at start+291.
- Random tx_ready (~50%) -> byte sequence identical to the tx_ready=1 run. tx_data is stable whenever tx_valid && !tx_ready.
- start re-pulsed at cycles 10 and 100 during a dump -> single frame of 194 bytes, one done pulse.
- reset asserted at byte 60 -> next cycle tx_valid=0, busy=0. A later start yields a full, correct frame.
- MEM_BASE=32'h40, MEM_WORDS=2 -> mem_addr sequence 0x40, 0x44; frame length 2+4*34=138.
- Registered-read model (1-cycle latency) vs combinational model -> identical frames.

Source files
------------

// File: rtl/dumper_pkg.sv
// Shared types and helpers for the CPU state dumper: FSM states, default header byte
// and frame-length arithmetic.
package dumper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    // Header + 4 bytes per word + checksum.
    function automatic int unsigned frame_len(input int unsigned nregs, input int unsigned nwords);
        return 2 + 4 * (nregs + nwords);
    endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// Splits a 32-bit word into four bytes, LSB first, and keeps the running XOR of
// every byte handed to the sink.
module dump_byte_serializer
    import dumper_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        take,
    output logic [7:0]  byte_out,
    output logic        last_byte,
    output logic [7:0]  csum
);

    logic [31:0] shreg;
    logic [1:0]  cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
            csum  <= '0;
        end else begin
            if (clear) begin
                csum <= '0;
            end
            if (load) begin
                shreg <= word;
                cnt   <= '0;
            end else if (take) begin
                shreg <= {8'h00, shreg[31:8]};
                cnt   <= cnt + 2'd1;
                csum  <= csum ^ shreg[7:0];
            end
        end
    end

    assign byte_out  = shreg[7:0];
    assign last_byte = (cnt == 2'd3);

endmodule

// File: rtl/cpu_state_dumper.sv
// Walks the register file then a window of data memory and streams the contents as
// a framed byte stream (header, little-endian words, XOR checksum).
module cpu_state_dumper
    import dumper_pkg::*;
#(
    parameter int          NUM_REGS  = 32,
    parameter int          MEM_WORDS = 16,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter logic [7:0]  HDR_BYTE  = HDR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [31:0] NREGS    = 32'(NUM_REGS);
    localparam logic [31:0] LAST_IDX = 32'(NUM_REGS + MEM_WORDS - 1);

    state_t      state, nstate;
    logic [31:0] index;
    logic        is_rf;
    logic        clr, load, take, inc;
    logic [7:0]  ser_byte, csum;
    logic        last_byte;

    // Addresses are a pure function of the index, so they hold steady from FETCH
    // through LATCH for both combinational and registered read ports.
    assign is_rf    = (index < NREGS);
    assign rf_addr  = is_rf ? index[4:0] : 5'd0;
    assign mem_addr = is_rf ? MEM_BASE : MEM_BASE + ((index - NREGS) << 2);

    dump_byte_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr),
        .load      (load),
        .word      (is_rf ? rf_data : mem_data),
        .take      (take),
        .byte_out  (ser_byte),
        .last_byte (last_byte),
        .csum      (csum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            index <= '0;
        end else begin
            state <= nstate;
            if (clr) begin
                index <= '0;
            end else if (inc) begin
                index <= index + 32'd1;
            end
        end
    end

    always_comb begin
        nstate   = state;
        busy     = 1'b0;
        done     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        clr      = 1'b0;
        load     = 1'b0;
        take     = 1'b0;
        inc      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nstate = ST_HDR;
                    clr    = 1'b1;
                end
            end
            ST_HDR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (tx_ready) nstate = ST_FETCH;
            end
            ST_FETCH: begin
                busy   = 1'b1;
                nstate = ST_LATCH;
            end
            ST_LATCH: begin
                busy   = 1'b1;
                load   = 1'b1;
                nstate = ST_SEND;
            end
            ST_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = ser_byte;
                if (tx_ready) begin
                    take = 1'b1;
                    if (last_byte) begin
                        inc    = 1'b1;
                        nstate = (index < LAST_IDX) ? ST_FETCH : ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) nstate = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                nstate = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Self-checking bench: random register/memory images, random sink backpressure and
// both read-port styles, checked against a frame built directly from the images.
module tb_cpu_state_dumper;

    logic        clk = 1'b0;
    logic        reset, start, busy, done, tx_valid;
    logic        tx_ready = 1'b1;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data, mem_addr, mem_data;
    logic [7:0]  tx_data;

    logic        reset2, start2, busy2, done2, tx_valid2;
    logic        tx_ready2 = 1'b1;
    logic [4:0]  rf_addr2;
    logic [31:0] rf_data2, mem_addr2, mem_data2;
    logic [7:0]  tx_data2;

    logic [31:0] regs [32];
    logic [31:0] mem  [64];
    logic [31:0] rf_q, mem_q;
    bit          regrd = 1'b0;
    bit          rnd_rdy = 1'b0;
    int          cyc = 0;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx[$];
    logic [7:0] rx2[$];
    int done_cnt, hdr_cyc, csum_cyc, done_cyc, stab_err, busy_at_done, done2_cnt;
    logic [31:0] addr_a, addr_b;
    bit         pstall;
    logic [7:0] pdata;
    int         k;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_state_dumper dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rf_addr(rf_addr), .rf_data(rf_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    cpu_state_dumper #(.MEM_WORDS(2), .MEM_BASE(32'h40)) dut2 (
        .clk(clk), .reset(reset2), .start(start2), .busy(busy2), .done(done2),
        .rf_addr(rf_addr2), .rf_data(rf_data2), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2)
    );

    // Memory models: combinational or one-cycle registered read for the main DUT.
    always @(posedge clk) begin
        rf_q  <= regs[rf_addr];
        mem_q <= mem[mem_addr[7:2]];
    end
    assign rf_data   = regrd ? rf_q  : regs[rf_addr];
    assign mem_data  = regrd ? mem_q : mem[mem_addr[7:2]];
    assign rf_data2  = regs[rf_addr2];
    assign mem_data2 = mem[mem_addr2[7:2]];

    always @(posedge clk) begin
        #1;
        tx_ready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        tx_ready2 = 1'b1;
    end

    always @(negedge clk) begin
        if (pstall && (!tx_valid || tx_data != pdata)) stab_err++;
        pstall = tx_valid && !tx_ready && !reset;
        pdata  = tx_data;
        if (tx_valid && tx_ready) begin
            if (rx.size() == 0)   hdr_cyc  = cyc;
            if (rx.size() == 193) csum_cyc = cyc;
            rx.push_back(tx_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) busy_at_done++;
        end
        if (tx_valid2 && tx_ready2) begin
            if (rx2.size() == 129) addr_a = mem_addr2;
            if (rx2.size() == 133) addr_b = mem_addr2;
            rx2.push_back(tx_data2);
        end
        if (done2) done2_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clr_mon();
        rx.delete();
        rx2.delete();
        done_cnt = 0; done2_cnt = 0; hdr_cyc = -1; csum_cyc = -1; done_cyc = -1;
        stab_err = 0; busy_at_done = 0; pstall = 1'b0;
        addr_a = 32'hx; addr_b = 32'hx;
    endtask

    // Reference frame straight from the dump rules: header, 32 regs, nw mem words
    // starting at word index base_idx, XOR of payload.
    task automatic build_exp(input int nw, input int base_idx);
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        x = 8'h00;
        for (int i = 0; i < 32 + nw; i++) begin
            w = (i < 32) ? regs[i] : mem[base_idx + i - 32];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                x ^= w[8*b +: 8];
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic cmp_frame(input string tag, input logic [7:0] got[$]);
        int bad = -1;
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        chk({tag, "_first_bad_byte"}, bad, -1);
    endtask

    function automatic logic [31:0] rxb(input int i);
        return (i < rx.size()) ? {24'h0, rx[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == n0; i++) @(posedge clk);
        chk({tag, "_done_seen"}, 32'(done_cnt > n0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic randomize_images();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = i;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
        reset = 1'b1; start = 1'b0; reset2 = 1'b1; start2 = 1'b0;
        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_addr2", mem_addr2, 32'h40);
        reset = 1'b0; reset2 = 1'b0;

        // Directed image, sink always ready: content and exact latency.
        build_exp(16, 0);
        clr_mon();
        pulse_start();
        chk("busy_after_start", busy, 1);
        wait_done("t1", 1000);
        cmp_frame("t1", rx);
        chk("t1_byte0", rxb(0), 32'hA5);
        chk("t1_byte1", rxb(1), 0);
        chk("t1_byte4", rxb(4), 0);
        chk("t1_byte5", rxb(5), 1);
        chk("t1_byte129", rxb(129), 32'h00);
        chk("t1_byte130", rxb(130), 32'h10);
        chk("t1_hdr_cycle", hdr_cyc - k, 0);
        chk("t1_csum_cycle", csum_cyc - k, 289);
        chk("t1_done_cycle", done_cyc - k, 290);
        chk("t1_done_count", done_cnt, 1);
        chk("t1_busy_at_done", busy_at_done, 0);
        chk("t1_idle_busy", busy, 0);

        // Random images: ready held, then random backpressure, then registered reads.
        for (int r = 0; r < 3; r++) begin
            randomize_images();
            build_exp(16, 0);
            clr_mon();
            rnd_rdy = 1'b0; regrd = 1'b0;
            pulse_start();
            wait_done("t2_ready", 1000);
            cmp_frame("t2_ready", rx);
            clr_mon();
            rnd_rdy = 1'b1;
            pulse_start();
            wait_done("t2_bp", 5000);
            cmp_frame("t2_bp", rx);
            chk("t2_bp_stable", stab_err, 0);
            clr_mon();
            regrd = 1'b1;
            pulse_start();
            wait_done("t2_regrd", 5000);
            cmp_frame("t2_regrd", rx);
            chk("t2_regrd_stable", stab_err, 0);
        end
        rnd_rdy = 1'b0; regrd = 1'b0;

        // Start re-pulsed mid-frame and during DONE: still one frame, one done.
        randomize_images();
        build_exp(16, 0);
        clr_mon();
        pulse_start();
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (89) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        cmp_frame("t3", rx);
        chk("t3_done_count", done_cnt, 1);
        chk("t3_busy_after", busy, 0);

        // Reset mid-frame, then a clean dump.
        clr_mon();
        pulse_start();
        for (int i = 0; i < 1000 && rx.size() < 60; i++) @(negedge clk);
        chk("t4_reached_byte60", 32'(rx.size() >= 60), 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("t4_rst_tx_valid", tx_valid, 0);
        chk("t4_rst_busy", busy, 0);
        reset = 1'b0;
        clr_mon();
        pulse_start();
        wait_done("t4", 1000);
        cmp_frame("t4", rx);

        // Offset memory window with two words.
        randomize_images();
        build_exp(2, 16);
        clr_mon();
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int i = 0; i < 1000 && done2_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_done", done2_cnt, 1);
        chk("t5_len_138", rx2.size(), 138);
        cmp_frame("t5", rx2);
        chk("t5_addr_word0", addr_a, 32'h40);
        chk("t5_addr_word1", addr_b, 32'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
